// File: rtl/bus_seq_prog_loader.sv
// Byte-stream loader for 13-bit sequencer program words into a RAM write port.
// Optional jump range check in the high-byte state: BUS_SEQ_LOADER_JMPCHK_EN.
module bus_seq_prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [12:0]       prog_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t      state;
  logic [7:0]  lo_q;
  logic        hs;
  logic        hi_bad;
  logic        jmp_bad;
  logic        is_stop;
  logic [12:0] word_nx;

  assign hs      = s_valid && s_ready;
  assign hi_bad  = |s_data[7:5];
  assign word_nx = {s_data[4:0], lo_q};
  assign is_stop = prog_wdata[3:0] == 4'd0;

`ifdef BUS_SEQ_LOADER_JMPCHK_EN
  localparam int TW = ADDR_W + 9;

  logic [7:0]    j_data;
  logic          j_is;
  logic [TW-1:0] t_addr;
  logic [TW-1:0] t_data;
  logic [TW-1:0] t_max;

  // Widened so neither the subtraction nor the sum can wrap.
  always_comb begin
    j_data  = {s_data[4:0], lo_q[7:5]};
    j_is    = !lo_q[0] &&
              (lo_q[3:1] == 3'd3 || lo_q[3:1] == 3'd5);
    t_addr  = TW'(prog_addr);
    t_data  = TW'(j_data);
    t_max   = TW'(ADDR_MAX);
    jmp_bad = 1'b0;
    if (j_is) begin
      if (lo_q[4]) jmp_bad = t_data > t_addr;
      else         jmp_bad = (t_addr + t_data) > t_max;
    end
  end
`else
  assign jmp_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lo_q       <= '0;
      s_ready    <= 1'b0;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= '0;
      word_count <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE || state == DONE || state == ERR): begin
          if (load_start) begin
            state      <= LO;
            s_ready    <= 1'b1;
            busy       <= 1'b1;
            prog_addr  <= '0;
            word_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= '0;
          end
        end
        (state == LO): begin
          if (hs) begin
            lo_q  <= s_data;
            state <= HI;
          end
        end
        (state == HI): begin
          if (hs) begin
            if (hi_bad || jmp_bad) begin
              state    <= ERR;
              s_ready  <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= hi_bad ? 2'd1 : 2'd3;
            end else begin
              state      <= WRITE;
              s_ready    <= 1'b0;
              prog_we    <= 1'b1;
              prog_wdata <= word_nx;
            end
          end
        end
        (state == WRITE): begin
          prog_we    <= 1'b0;
          word_count <= word_count + 1'b1;
          if (is_stop) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (prog_addr == ADDR_MAX) begin
            state    <= ERR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= 2'd2;
          end else begin
            state     <= LO;
            prog_addr <= prog_addr + 1'b1;
            s_ready   <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          prog_we <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_seq_prog_loader.sv
// Bench for bus_seq_prog_loader: vector table, corner sequences, random loads.
// Expectations follow BUS_SEQ_LOADER_JMPCHK_EN when it is defined.
module tb_bus_seq_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [7:0]  s_data;
  logic        s_valid;

  logic        s_ready, prog_we, busy, done, error;
  logic [7:0]  prog_addr;
  logic [12:0] prog_wdata;
  logic [1:0]  err_code;
  logic [8:0]  word_count;

  logic        s_ready2, prog_we2, busy2, done2, error2;
  logic [1:0]  prog_addr2;
  logic [12:0] prog_wdata2;
  logic [1:0]  err_code2;
  logic [2:0]  word_count2;

  always #5 clk = ~clk;

  bus_seq_prog_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .word_count(word_count)
  );

  bus_seq_prog_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .load_start(load_start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
    .prog_we(prog_we2), .prog_addr(prog_addr2),
    .prog_wdata(prog_wdata2), .busy(busy2), .done(done2),
    .error(error2), .err_code(err_code2), .word_count(word_count2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wa[$];
  int wd[$];
  int wc[$];
  int w2[$];

  always @(negedge clk) begin
    cyc++;
    if (prog_we) begin
      wa.push_back(int'(prog_addr));
      wd.push_back(int'(prog_wdata));
      wc.push_back(cyc);
    end
    if (prog_we2) w2.push_back(int'(prog_addr2));
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic clrq();
    wa.delete(); wd.delete(); wc.delete(); w2.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; load_start = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL hs_timeout act=%0d exp=handshake", n);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] lo, input logic [7:0] hi);
    send_byte(lo, 0);
    send_byte(hi, 0);
  endtask

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        we;
    logic [12:0] wdata;
    logic        dn;
    logic        er;
    logic [1:0]  code;
    logic        bsy;
  } vec_t;

  vec_t vt[10];

  // Model of a whole load, expressed as a walk over the word list.
  logic [7:0] ml[256];
  logic [7:0] mh[256];
  int ew_a[$];
  int ew_d[$];
  int m_used, m_done, m_err, m_code;

  task automatic model();
    int addr, data, tgt, op;
    ew_a.delete(); ew_d.delete();
    addr = 0; m_done = 0; m_err = 0; m_code = 0; m_used = 0;
    for (int i = 0; i < 256; i++) begin
      m_used = i + 1;
      if (mh[i][7:5] != 3'd0) begin
        m_err = 1; m_code = 1; break;
      end
`ifdef BUS_SEQ_LOADER_JMPCHK_EN
      op = int'(ml[i][3:1]);
      if (!ml[i][0] && (op == 3 || op == 5)) begin
        data = int'(mh[i][4:0]) * 8 + int'(ml[i][7:5]);
        tgt  = ml[i][4] ? addr - data : addr + data;
        if (tgt < 0 || tgt > 255) begin
          m_err = 1; m_code = 3; break;
        end
      end
`endif
      ew_a.push_back(addr);
      ew_d.push_back(int'(mh[i][4:0]) * 256 + int'(ml[i]));
      if (ml[i][3:0] == 4'd0) begin
        m_done = 1; break;
      end
      if (addr == 255) begin
        m_err = 1; m_code = 2; break;
      end
      addr++;
    end
  endtask

  initial begin
    int bad;
    bit jchk;
`ifdef BUS_SEQ_LOADER_JMPCHK_EN
    jchk = 1'b1;
`else
    jchk = 1'b0;
`endif
    vt[0] = '{8'h03, 8'h15, 1, 13'h1503, 0, 0, 0, 1};
    vt[1] = '{8'h00, 8'h00, 1, 13'h0000, 1, 0, 0, 0};
    vt[2] = '{8'h00, 8'h20, 0, 13'h0000, 0, 1, 1, 0};
    vt[3] = jchk ? '{8'h5A, 8'h00, 0, 13'h0000, 0, 1, 3, 0}
                 : '{8'h5A, 8'h00, 1, 13'h005A, 0, 0, 0, 1};
    vt[4] = '{8'h4A, 8'h00, 1, 13'h004A, 0, 0, 0, 1};
    vt[5] = '{8'hF7, 8'h1F, 1, 13'h1FF7, 0, 0, 0, 1};
    vt[6] = '{8'h00, 8'h1F, 1, 13'h1F00, 1, 0, 0, 0};
    vt[7] = jchk ? '{8'h36, 8'h1F, 0, 13'h0000, 0, 1, 3, 0}
                 : '{8'h36, 8'h1F, 1, 13'h1F36, 0, 0, 0, 1};
    vt[8] = '{8'h26, 8'h1F, 1, 13'h1F26, 0, 0, 0, 1};
    vt[9] = '{8'h01, 8'h80, 0, 13'h0000, 0, 1, 1, 0};

    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_we", prog_we, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_wdata", prog_wdata, 0);
    chk("rst_flags", {done, error, err_code}, 0);
    chk("rst_cnt", word_count, 0);

    foreach (vt[i]) begin
      do_reset();
      clrq();
      start();
      send_word(vt[i].lo, vt[i].hi);
      @(negedge clk);
      chk($sformatf("v%0d_nwr", i), wd.size(), vt[i].we);
      if (wd.size() > 0) begin
        chk($sformatf("v%0d_wdata", i), wd[0], vt[i].wdata);
        chk($sformatf("v%0d_waddr", i), wa[0], 0);
      end
      chk($sformatf("v%0d_done", i), done, vt[i].dn);
      chk($sformatf("v%0d_err", i), error, vt[i].er);
      chk($sformatf("v%0d_code", i), err_code, vt[i].code);
      chk($sformatf("v%0d_busy", i), busy, vt[i].bsy);
      chk($sformatf("v%0d_srdy", i), s_ready, vt[i].bsy);
      chk($sformatf("v%0d_cnt", i), word_count, vt[i].we);
    end

    // Two-word program; back-to-back bytes give one word per 3 cycles.
    do_reset(); clrq();
    start();
    send_word(8'h03, 8'h15);
    send_word(8'h00, 8'h00);
    @(negedge clk);
    chk("two_nwr", wd.size(), 2);
    if (wd.size() == 2) begin
      chk("two_w0", {wa[0], wd[0]}, {32'd0, 32'h1503});
      chk("two_w1", {wa[1], wd[1]}, {32'd1, 32'h0000});
      chk("two_gap", wc[1] - wc[0], 3);
    end
    chk("two_done", {done, error, busy}, 3'b100);
    chk("two_cnt", word_count, 2);

    // load_start while busy must not restart the address.
    do_reset(); clrq();
    start();
    send_word(8'h01, 8'h00);
    start();
    send_word(8'h00, 8'h00);
    @(negedge clk);
    chk("ign_nwr", wa.size(), 2);
    if (wa.size() == 2) chk("ign_a1", wa[1], 1);
    chk("ign_cnt", word_count, 2);

    // ADDR_W=2 overflow after four non-STOP words.
    do_reset(); clrq();
    start();
    for (int k = 0; k < 4; k++) send_word(8'h01, 8'h00);
    @(negedge clk);
    chk("ovf_nwr", w2.size(), 4);
    if (w2.size() == 4)
      chk("ovf_addrs", {w2[0], w2[1], w2[2], w2[3]},
          {32'd0, 32'd1, 32'd2, 32'd3});
    chk("ovf_err", {error2, err_code2, busy2, done2}, 5'b1_10_00);
    chk("ovf_cnt", word_count2, 4);

    // Upward jump past address 0 from address 1.
    do_reset(); clrq();
    start();
    send_word(8'h01, 8'h00);
    send_word(8'h5A, 8'h00);
    @(negedge clk);
    if (jchk) begin
      chk("jmp_nwr", wa.size(), 1);
      chk("jmp_err", {error, err_code}, 3'b1_11);
    end else begin
      chk("jmp_nwr", wa.size(), 2);
      if (wa.size() == 2) chk("jmp_w1", {wa[1], wd[1]}, {32'd1, 32'h5A});
      chk("jmp_err", {error, err_code}, 3'b0_00);
    end

    // Reset while in HI.
    do_reset(); clrq();
    start();
    send_byte(8'h03, 0);
    s_data = 8'h15; s_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("mr_outs", {s_ready, prog_we, busy, done, error, err_code},
        0);
    chk("mr_addr", {prog_addr, word_count, prog_wdata}, 0);
    repeat (3) @(negedge clk);
    chk("mr_nwr", wa.size(), 0);
    s_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    start();
    send_word(8'h00, 8'h00);
    @(negedge clk);
    chk("mr_restart", wa.size(), 1);
    if (wa.size() == 1) chk("mr_a0", wa[0], 0);
    chk("mr_done", done, 1);

    // Random loads compared against the word-walk model.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 256; i++) begin
        ml[i] = 8'($urandom);
        if (t % 4 == 0) ml[i][0] = 1'b1;
        mh[i] = ($urandom_range(0, 15) == 0) ? 8'($urandom)
                                             : {3'b000, 5'($urandom)};
      end
      model();
      clrq();
      start();
      for (int i = 0; i < m_used; i++) begin
        send_byte(ml[i], $urandom_range(0, 2));
        send_byte(mh[i], $urandom_range(0, 2));
      end
      repeat (2) @(negedge clk);
      chk($sformatf("r%0d_nwr", t), wa.size(), ew_a.size());
      bad = 0;
      if (wa.size() == ew_a.size())
        foreach (ew_a[k])
          if (wa[k] != ew_a[k] || wd[k] != ew_d[k]) bad++;
      chk($sformatf("r%0d_wbad", t), bad, 0);
      chk($sformatf("r%0d_flags", t), {busy, done, error, err_code},
          {1'b0, 1'(m_done), 1'(m_err), 2'(m_code)});
      chk($sformatf("r%0d_cnt", t), word_count, ew_a.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_seq_prog_loader.md
BUS_SEQ_PROG_LOADER -- requirements
Module: bus_seq_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program memory address width (depth 2^ADDR_W words).
REQ-002 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port load_start  in  1  one-cycle pulse; begins a program load.
REQ-005 SHALL have ports s_data in 8, s_valid in 1, s_ready out 1; host byte stream, transfer when s_valid && s_ready.
REQ-006 SHALL have ports prog_we out 1, prog_addr out ADDR_W, prog_wdata out 13; program RAM write port.
REQ-007 SHALL have ports busy out 1, done out 1, error out 1, err_code out 2, word_count out ADDR_W+1.

Function
REQ-008 SHALL use this 13-bit sequencer word layout:
- bit0: cmd (1 = bus transfer, 0 = instruction).
- Instruction: [3:1] opcode (0 STOP, 1 WAIT, 2 COMPARE, 3 COMP_JMP, 4 PAUSE, 5 UNCOND_JMP, 6/7 NOP); [4] config (for jumps, 1 = up, 0 = down); [12:5] data.
- Transfer: [4:1] config; [12:5] data.
REQ-009 SHALL implement FSM states IDLE, LO, HI, WRITE, DONE, ERR.
REQ-010 IDLE/DONE/ERR: load_start -> LO; prog_addr and word_count cleared to 0; done, error and err_code cleared.
REQ-011 LO: s_ready=1; on handshake, latch s_data as word bits [7:0] -> HI.
REQ-012 HI: s_ready=1; on handshake, s_data[4:0] form word bits [12:8]; if s_data[7:5]!=0 -> ERR, err_code=1, no write; otherwise -> WRITE.
REQ-013 WRITE: s_ready=0, prog_we=1 for exactly one cycle with the assembled word at prog_addr; word_count increments.
REQ-014 From WRITE:
- STOP instruction (cmd=0, opcode=0) -> DONE.
- Otherwise, prog_addr == 2^ADDR_W-1 -> ERR, err_code=2 (overflow, no STOP).
- Otherwise prog_addr increments -> LO.
REQ-015 Latency: one word is written on the cycle after the second byte handshake; maximum throughput is one word per 3 cycles.
REQ-016 busy=1 in LO, HI and WRITE; s_ready=0 in all other states; load_start is ignored while busy.
REQ-017 done and error SHALL be level outputs held until the next load_start or reset; err_code is 0 when error=0.
REQ-018 prog_we SHALL be 0 in all states except WRITE.

Reset
REQ-019 rst SHALL force state IDLE and these outputs to 0: prog_addr, word_count, done, error, err_code, prog_we, s_ready, busy; prog_wdata SHALL be 0.
REQ-020 Reset mid-load SHALL abort immediately with no further prog_we; partial RAM contents are left as written.

Configuration
REQ-021 With BUS_SEQ_LOADER_JMPCHK_EN defined, the block SHALL range-check jumps in HI for instructions with opcode 3 or 5:
- Target = prog_addr - data when config=1; target = prog_addr + data when config=0.
- A target < 0 or > 2^ADDR_W-1 -> ERR, err_code=3, no write.
REQ-022 Without BUS_SEQ_LOADER_JMPCHK_EN, the block SHALL apply no jump check, and err_code 3 SHALL never occur.

Verification
REQ-023 load_start, then bytes 0x03,0x15, 0x00,0x00 -> writes at addr0 0x1503 and at addr1 0x0000; done=1, word_count=2.
REQ-024 Second byte 0x20 -> no write, error=1, err_code=1, s_ready=0.
REQ-025 ADDR_W=2, four non-STOP words -> 4 writes at addr 0..3, then error=1, err_code=2.
REQ-026 With macro: at addr1, word UNCOND_JMP up, data=2 (bytes 0x5A,0x00) -> error, err_code=3, no write; without macro -> word written at addr1.
REQ-027 rst asserted during HI -> prog_we stays 0, all outputs 0; next load_start restarts at addr0.
